multicycle_control_g7: RTL and testbench

Multicycle control unit for the g7 RISC-V core. It replaces the single-cycle opcode decoder with a state machine that sequences fetch, decode, execute, memory and writeback over several clocks. It handles memory wait states through a ready handshake, traps on illegal opcodes and memory timeouts, and counts retired instructions. It sits between the instruction register and the datapath multiplexers, register file, ALU control and memory interface.

---
 rtl/multicycle_control_g7_if.sv | 11 +
 rtl/multicycle_control_g7.sv | 182 ++++++++++++++++++
 tb/tb_multicycle_control_g7.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_g7_if.sv
// multicycle_control_g7_if: memory handshake between the control unit and the memory port
//   mem_read  : read strobe, driven by the controller
//   mem_write : write strobe, driven by the controller
//   mem_ready : access completes in any cycle where a strobe and this are high
interface multicycle_control_g7_if;
    logic mem_read;
    logic mem_write;
    logic mem_ready;
    modport master (output mem_read, output mem_write, input mem_ready);
    modport slave (input mem_read, input mem_write, output mem_ready);
endinterface

// File: rtl/multicycle_control_g7.sv
// multicycle_control_g7: multicycle FSM control unit for the g7 RISC-V core
//   clk, rst      : clock, synchronous active-high reset
//   i_opcode      : IR[6:0], stable from DECODE until the instruction ends
//   mem_bus       : memory strobes out, mem_ready in
//   o_PCWrite, o_PCWriteCond, o_PCSrc, o_IRWrite, o_RegWrite, o_MemtoReg,
//   o_ALUSrcA, o_ALUSrcB, o_ALUOp : datapath controls
//   o_instr_done  : pulse in the final cycle of each instruction
//   o_retired     : retired-instruction count, wraps
//   o_trap        : error flag (held until reset)
//   o_state       : current state for debug
//   CTRL_G7_JUMP_EN : when defined, JAL/JALR are executed instead of trapping
module multicycle_control_g7 #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           i_opcode,
    multicycle_control_g7_if.master mem_bus,
    output logic                 o_PCWrite,
    output logic                 o_PCWriteCond,
    output logic                 o_PCSrc,
    output logic                 o_IRWrite,
    output logic                 o_RegWrite,
    output logic [1:0]           o_MemtoReg,
    output logic                 o_ALUSrcA,
    output logic [1:0]           o_ALUSrcB,
    output logic [1:0]           o_ALUOp,
    output logic                 o_instr_done,
    output logic [CNT_W-1:0]     o_retired,
    output logic                 o_trap,
    output logic [3:0]           o_state
);
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EX_R     = 4'd2,
        EX_I     = 4'd3,
        MEM_ADDR = 4'd4,
        MEM_RD   = 4'd5,
        MEM_WR   = 4'd6,
        WB_ALU   = 4'd7,
        WB_MEM   = 4'd8,
        BRANCH   = 4'd9,
`ifdef CTRL_G7_JUMP_EN
        JUMP     = 4'd10,
`endif
        TRAP     = 4'd11
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [WW-1:0]     r_wait;
    logic [CNT_W-1:0]  r_retired;
    logic              w_ready;
    logic              w_waiting;
    logic              w_timeout;

    assign w_ready   = mem_bus.mem_ready;
    assign w_waiting = (r_state == FETCH || r_state == MEM_RD || r_state == MEM_WR) && !w_ready;
    // the TIMEOUT-th consecutive low cycle is the one where the count already equals TIMEOUT-1
    assign w_timeout = w_waiting && (r_wait == WW'(TIMEOUT - 1));
    assign o_retired = r_retired;
    assign o_state   = r_state;
    assign o_trap    = r_state == TRAP;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= FETCH;
            r_wait    <= '0;
            r_retired <= '0;
        end else begin
            r_state   <= w_next;
            r_wait    <= (w_waiting && w_next == r_state) ? r_wait + 1'b1 : '0;
            r_retired <= r_retired + CNT_W'(o_instr_done);
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            FETCH:    w_next = w_ready ? DECODE : w_timeout ? TRAP : FETCH;
            DECODE: begin
                case (i_opcode)
                    7'b0110011:             w_next = EX_R;
                    7'b0010011:             w_next = EX_I;
                    7'b0000011, 7'b0100011: w_next = MEM_ADDR;
                    7'b1100011:             w_next = BRANCH;
`ifdef CTRL_G7_JUMP_EN
                    7'b1101111, 7'b1100111: w_next = JUMP;
`endif
                    default:                w_next = TRAP;
                endcase
            end
            EX_R, EX_I: w_next = WB_ALU;
            MEM_ADDR: w_next = i_opcode[5] ? MEM_WR : MEM_RD;
            MEM_RD:   w_next = w_ready ? WB_MEM : w_timeout ? TRAP : MEM_RD;
            MEM_WR:   w_next = w_ready ? FETCH : w_timeout ? TRAP : MEM_WR;
            WB_ALU, WB_MEM, BRANCH: w_next = FETCH;
`ifdef CTRL_G7_JUMP_EN
            JUMP:     w_next = FETCH;
`endif
            TRAP:     w_next = TRAP;
            default:  w_next = TRAP;
        endcase
    end

    always_comb begin
        o_PCWrite         = 1'b0;
        o_PCWriteCond     = 1'b0;
        o_PCSrc           = 1'b0;
        o_IRWrite         = 1'b0;
        o_RegWrite        = 1'b0;
        o_MemtoReg        = 2'b00;
        o_ALUSrcA         = 1'b0;
        o_ALUSrcB         = 2'b00;
        o_ALUOp           = 2'b00;
        o_instr_done      = 1'b0;
        mem_bus.mem_read  = 1'b0;
        mem_bus.mem_write = 1'b0;
        case (r_state)
            FETCH: begin
                mem_bus.mem_read = 1'b1;
                o_ALUSrcB        = 2'b01;
                o_IRWrite        = w_ready;
                o_PCWrite        = w_ready;
            end
            DECODE: o_ALUSrcB = 2'b10;
            EX_R: begin
                o_ALUSrcA = 1'b1;
                o_ALUOp   = 2'b10;
            end
            EX_I: begin
                o_ALUSrcA = 1'b1;
                o_ALUSrcB = 2'b10;
                o_ALUOp   = 2'b10;
            end
            MEM_ADDR: begin
                o_ALUSrcA = 1'b1;
                o_ALUSrcB = 2'b10;
            end
            MEM_RD: mem_bus.mem_read = 1'b1;
            MEM_WR: begin
                mem_bus.mem_write = 1'b1;
                o_instr_done      = w_ready;
            end
            WB_ALU: begin
                o_RegWrite   = 1'b1;
                o_instr_done = 1'b1;
            end
            WB_MEM: begin
                o_RegWrite   = 1'b1;
                o_MemtoReg   = 2'b01;
                o_instr_done = 1'b1;
            end
            BRANCH: begin
                o_ALUSrcA     = 1'b1;
                o_ALUOp       = 2'b01;
                o_PCWriteCond = 1'b1;
                o_PCSrc       = 1'b1;
                o_instr_done  = 1'b1;
            end
`ifdef CTRL_G7_JUMP_EN
            JUMP: begin
                o_RegWrite   = 1'b1;
                o_MemtoReg   = 2'b10;
                o_PCWrite    = 1'b1;
                o_instr_done = 1'b1;
                // JAL takes the target from ALUOut; JALR computes rs1+imm this cycle
                o_PCSrc      = i_opcode == 7'b1101111;
                if (i_opcode == 7'b1100111) begin
                    o_ALUSrcA = 1'b1;
                    o_ALUSrcB = 2'b10;
                end
            end
`endif
            default: ;
        endcase
    end
endmodule

// File: tb/tb_multicycle_control_g7.sv
// tb_multicycle_control_g7: self-checking bench for multicycle_control_g7
module tb_multicycle_control_g7;
    localparam int CW = 2;
    localparam int TO = 4;
    localparam int S_FETCH = 0, S_DECODE = 1, S_EXR = 2, S_EXI = 3, S_MADDR = 4, S_MRD = 5;
    localparam int S_MWR = 6, S_WBALU = 7, S_WBMEM = 8, S_BR = 9, S_JUMP = 10, S_TRAP = 11;
    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111, OP_BAD = 7'b1111111;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [6:0] opcode = '0;
    logic PCWrite, PCWriteCond, PCSrc, IRWrite, RegWrite, ALUSrcA, instr_done, trap;
    logic [1:0] MemtoReg, ALUSrcB, ALUOp;
    logic [CW-1:0] retired;
    logic [3:0] state;
    int checks = 0;
    int errors = 0;
    int ret_m = 0;
    int q_st[$];
    bit q_rd[$];

    multicycle_control_g7_if bus ();

    multicycle_control_g7 #(.CNT_W(CW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .i_opcode(opcode), .mem_bus(bus),
        .o_PCWrite(PCWrite), .o_PCWriteCond(PCWriteCond), .o_PCSrc(PCSrc),
        .o_IRWrite(IRWrite), .o_RegWrite(RegWrite), .o_MemtoReg(MemtoReg),
        .o_ALUSrcA(ALUSrcA), .o_ALUSrcB(ALUSrcB), .o_ALUOp(ALUOp),
        .o_instr_done(instr_done), .o_retired(retired), .o_trap(trap), .o_state(state)
    );

    always #5 clk = ~clk;

    // control word: {PCWrite,PCWriteCond,PCSrc,IRWrite,MemRead,MemWrite,RegWrite,MemtoReg,ALUSrcA,ALUSrcB,ALUOp,instr_done,trap}
    function automatic logic [15:0] ctl(input int st, input logic [6:0] op, input logic rdy);
        logic pcw = 0, pcc = 0, pcs = 0, irw = 0, mr = 0, mw = 0, rw = 0, a = 0, d = 0, t = 0;
        logic [1:0] m2r = 0, b = 0, alu = 0;
        case (st)
            S_FETCH:  begin mr = 1; b = 2'b01; irw = rdy; pcw = rdy; end
            S_DECODE: b = 2'b10;
            S_EXR:    begin a = 1; alu = 2'b10; end
            S_EXI:    begin a = 1; b = 2'b10; alu = 2'b10; end
            S_MADDR:  begin a = 1; b = 2'b10; end
            S_MRD:    mr = 1;
            S_MWR:    begin mw = 1; d = rdy; end
            S_WBALU:  begin rw = 1; d = 1; end
            S_WBMEM:  begin rw = 1; m2r = 2'b01; d = 1; end
            S_BR:     begin a = 1; alu = 2'b01; pcc = 1; pcs = 1; d = 1; end
            S_JUMP:   begin
                rw = 1; m2r = 2'b10; pcw = 1; d = 1;
                if (op == OP_JAL) pcs = 1;
                else begin a = 1; b = 2'b10; end
            end
            default:  t = 1;
        endcase
        return {pcw, pcc, pcs, irw, mr, mw, rw, m2r, a, b, alu, d, t};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_cycle(input int st, input logic [6:0] op, input logic rdy);
        chk("state", 32'(state), 32'(st));
        chk("ctrl", 32'({PCWrite, PCWriteCond, PCSrc, IRWrite, bus.mem_read, bus.mem_write, RegWrite,
                         MemtoReg, ALUSrcA, ALUSrcB, ALUOp, instr_done, trap}), 32'(ctl(st, op, rdy)));
        chk("retired", 32'(retired), 32'(ret_m % (1 << CW)));
    endtask

    task automatic p(input int s, input bit r);
        q_st.push_back(s);
        q_rd.push_back(r);
    endtask

    // expected state sequence of one instruction from its class and wait counts
    task automatic build(input logic [6:0] op, input int wf, input int wm, output bit tr);
        int ms;
        q_st.delete();
        q_rd.delete();
        tr = 0;
        if (wf >= TO) begin
            repeat (TO) p(S_FETCH, 0);
            p(S_TRAP, 1'($urandom_range(0, 1)));
            tr = 1;
            return;
        end
        repeat (wf) p(S_FETCH, 0);
        p(S_FETCH, 1);
        p(S_DECODE, 1'($urandom_range(0, 1)));
        case (op)
            OP_R, OP_I: begin
                p(op == OP_R ? S_EXR : S_EXI, 1'($urandom_range(0, 1)));
                p(S_WBALU, 1'($urandom_range(0, 1)));
            end
            OP_LD, OP_ST: begin
                p(S_MADDR, 1'($urandom_range(0, 1)));
                ms = (op == OP_ST) ? S_MWR : S_MRD;
                if (wm >= TO) begin
                    repeat (TO) p(ms, 0);
                    p(S_TRAP, 1);
                    tr = 1;
                end else begin
                    repeat (wm) p(ms, 0);
                    p(ms, 1);
                    if (op == OP_LD) p(S_WBMEM, 1'($urandom_range(0, 1)));
                end
            end
            OP_BR: p(S_BR, 1'($urandom_range(0, 1)));
`ifdef CTRL_G7_JUMP_EN
            OP_JAL, OP_JALR: p(S_JUMP, 1'($urandom_range(0, 1)));
`endif
            default: begin
                p(S_TRAP, 1'($urandom_range(0, 1)));
                tr = 1;
            end
        endcase
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.mem_ready = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        rst = 1'b0;
        ret_m = 0;
        bus.mem_ready = 1'b0;
        #1;
        check_cycle(S_FETCH, opcode, 1'b0);
    endtask

    task automatic trap_hold(input int n);
        repeat (n) begin
            bus.mem_ready = 1'($urandom_range(0, 1));
            opcode = 7'($urandom);
            #1;
            check_cycle(S_TRAP, opcode, bus.mem_ready);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run(input logic [6:0] op, input int wf, input int wm, input int cut);
        bit tr;
        int n;
        build(op, wf, wm, tr);
        n = cut > 0 ? cut : q_st.size();
        for (int i = 0; i < n; i++) begin
            opcode = (q_st[i] == S_FETCH) ? 7'($urandom) : op;
            bus.mem_ready = q_rd[i];
            #1;
            check_cycle(q_st[i], opcode, q_rd[i]);
            @(posedge clk);
            #1;
        end
        if (cut == 0 && !tr) ret_m++;
        if (tr) begin
            trap_hold(20);
            do_reset();
        end
    endtask

    initial begin
        logic [6:0] ops[7] = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR};
        bus.mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        run(OP_R, 0, 0, 0);
        run(OP_LD, 2, 3, 0);
        run(OP_BR, 0, 0, 0);
        run(OP_ST, 1, 2, 0);
        run(OP_I, 0, 0, 0);
        run(OP_BAD, 0, 0, 0);
        run(OP_R, TO, 0, 0);
        run(OP_LD, 0, TO, 0);
        run(OP_ST, 0, TO, 0);
        run(OP_LD, 0, 3, 4);
        do_reset();
        run(OP_R, TO - 1, 0, 0);
        run(OP_JAL, 0, 0, 0);
        run(OP_JALR, 1, 0, 0);
        for (int k = 0; k < 40; k++)
            run(ops[$urandom_range(0, 6)], int'($urandom_range(0, TO - 1)), int'($urandom_range(0, TO - 1)), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
